mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max cycles mem_valid_o may wait for mem_ack_i before abort (range 2..255).
REQ-002 SHALL have ports, in order:
clk_i  in  1  single clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
instr_mem_rd_i  in  1  CPU fetch request.
instr_mem_addr_i  in  32  fetch address.
instr_mem_data_o  out  32  fetched word.
instr_mem_ready_o  out  1  CPU may advance.
data_mem_rd_i  in  1  CPU load request.
data_mem_wr_i  in  1  CPU store request.
data_mem_addr_i  in  32  load/store address.
data_mem_data_i  in  32  store data, lane-aligned.
byte_select_i  in  4  store lane enables.
data_mem_data_o  out  32  load word.
data_mem_ready_o  out  1  CPU may advance.
mem_valid_o  out  1  shared-memory request.
mem_we_o  out  1  write strobe.
mem_addr_o  out  32  word address.
mem_wdata_o  out  32  write data.
mem_be_o  out  4  byte enables.
mem_rdata_i  in  32  read data, valid with ack.
mem_ack_i  in  1  access complete.
err_o  out  1  sticky timeout flag.

Function
REQ-003 SHALL share one memory port between fetch and data ports; FSM states IDLE, DATA, INSTR, DONE.
REQ-004 IDLE: no request -> both readies high, stay; data rd|wr -> DATA; else fetch only -> INSTR; both readies low whenever any request present.
REQ-005 Requests, address, wdata, byte_select SHALL be latched on IDLE exit; input changes ignored until return to IDLE.
REQ-006 DATA: mem_valid_o high, mem_we_o=latched wr, mem_be_o=byte_select (4'hF for loads), mem_wdata_o=latched data; on mem_ack_i capture rdata (loads) -> INSTR if fetch latched, else DONE.
REQ-007 INSTR: mem_valid_o high, mem_we_o low, mem_be_o 4'hF; on mem_ack_i capture rdata into instr buffer -> DONE.
REQ-008 mem_addr_o SHALL be {addr[31:2],2'b00}; mem_* outputs held stable while mem_valid_o high and ack low.
REQ-009 DONE: both readies high exactly one cycle, data outputs show buffers -> IDLE; buffers held until next capture.
REQ-010 Both readies SHALL always be equal (CPU advances only when both high).
REQ-011 Registered FSM; zero-wait memory (ack in first valid cycle) gives ready at 4th cycle after request (IDLE, DATA, INSTR, DONE); fetch-only gives 3.
REQ-012 Wait counter SHALL clear on entering DATA/INSTR; reaching TIMEOUT with no ack SHALL drop mem_valid_o, load 32'h0000_0013 (NOP) into instr buffer or 32'h0 into data buffer, set err_o, continue sequence as if acked.
REQ-013 mem_ack_i while mem_valid_o low SHALL be ignored.
REQ-014 Store SHALL not capture mem_rdata_i; data_mem_data_o keeps previous load value.

Reset
REQ-015 rst_i high SHALL asynchronously force IDLE, mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, both buffers=0, err_o=0, counter=0, readies=1.
REQ-016 Reset mid-access SHALL abandon the transfer; a late ack after reset is ignored per REQ-013.

Structure
REQ-017 FSM state encoding and NOP constant SHALL live in shared package mero_mem_pkg.
REQ-018 Single module; timeout counter inline, no sub-module.

Verification
REQ-019 Fetch only 0x100, ack same cycle, rdata 0x00A00093 -> mem_addr_o 0x100, ready both high cycle 3, instr_mem_data_o 0x00A00093.
REQ-020 Load 0x2004 + fetch 0x104, ack 2 cycles late each -> data access first, data_mem_data_o=mem value, readies high once, cycle 8.
REQ-021 Store 0x2001 be 4'b0010 wdata 0x0000AB00 -> mem_addr_o 0x2000, mem_we_o 1, mem_be_o 0010, then fetch, no data buffer update.
REQ-022 No ack, TIMEOUT=4 -> mem_valid_o drops after 4 cycles, instr_mem_data_o 0x00000013, err_o stays 1 until reset.
REQ-023 Assert rst_i mid-DATA then ack next cycle -> outputs reset values immediately, ack ignored, readies high.
REQ-024 Change data_mem_addr_i during DATA wait -> mem_addr_o unchanged until ack.

Source files
------------

// File: rtl/mero_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding,
// the fetch value substituted on an aborted access, and word alignment.
package mero_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_INSTR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [3:0]  BE_ALL    = 4'hF;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU fetch and load/store; data access goes first, then fetch.
// Zero-wait: ready 4 cycles after a data+fetch request (3 for fetch only); waits stall the CPU, TIMEOUT aborts.
module mem_arbiter
  import mero_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_mem_rd_i,
  input  logic [31:0] instr_mem_addr_i,
  output logic [31:0] instr_mem_data_o,
  output logic        instr_mem_ready_o,
  input  logic        data_mem_rd_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [31:0] data_mem_data_i,
  input  logic [3:0]  byte_select_i,
  output logic [31:0] data_mem_data_o,
  output logic        data_mem_ready_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_wr;
  logic        r_fetch;
  logic [31:0] r_iaddr;
  logic [31:0] r_ibuf;
  logic [31:0] r_dbuf;
  logic        r_err;

  logic w_any_req;
  logic w_data_req;
  logic w_timeout;
  logic w_finish;
  logic w_ready;

  assign w_data_req = data_mem_rd_i | data_mem_wr_i;
  assign w_any_req  = w_data_req | instr_mem_rd_i;
  assign w_timeout  = (r_cnt == TO_LAST) & ~mem_ack_i;
  assign w_finish   = mem_ack_i | w_timeout;

  // Ready drops in the same cycle a request appears so the CPU never slips past it.
  assign w_ready = rst_i | (r_state == ST_DONE) | ((r_state == ST_IDLE) & ~w_any_req);

  assign instr_mem_ready_o = w_ready;
  assign data_mem_ready_o  = w_ready;
  assign instr_mem_data_o  = r_ibuf;
  assign data_mem_data_o   = r_dbuf;
  assign err_o             = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_wr        <= 1'b0;
      r_fetch     <= 1'b0;
      r_iaddr     <= 32'h0;
      r_ibuf      <= 32'h0;
      r_dbuf      <= 32'h0;
      r_err       <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_be_o    <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 8'd0;
          if (w_data_req) begin
            r_state     <= ST_DATA;
            r_wr        <= data_mem_wr_i;
            r_fetch     <= instr_mem_rd_i;
            r_iaddr     <= word_addr(instr_mem_addr_i);
            mem_valid_o <= 1'b1;
            mem_we_o    <= data_mem_wr_i;
            mem_addr_o  <= word_addr(data_mem_addr_i);
            mem_wdata_o <= data_mem_data_i;
            mem_be_o    <= data_mem_wr_i ? byte_select_i : BE_ALL;
          end else if (instr_mem_rd_i) begin
            r_state     <= ST_INSTR;
            r_wr        <= 1'b0;
            r_fetch     <= 1'b1;
            r_iaddr     <= word_addr(instr_mem_addr_i);
            mem_valid_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= word_addr(instr_mem_addr_i);
            mem_be_o    <= BE_ALL;
          end
        end

        ST_DATA: begin
          if (w_finish) begin
            // Stores leave the load buffer untouched, even on abort.
            if (!r_wr) r_dbuf <= mem_ack_i ? mem_rdata_i : 32'h0;
            if (w_timeout) r_err <= 1'b1;
            r_cnt    <= 8'd0;
            mem_we_o <= 1'b0;
            if (r_fetch) begin
              r_state     <= ST_INSTR;
              mem_valid_o <= 1'b1;
              mem_addr_o  <= r_iaddr;
              mem_be_o    <= BE_ALL;
            end else begin
              r_state     <= ST_DONE;
              mem_valid_o <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_INSTR: begin
          if (w_finish) begin
            r_ibuf      <= mem_ack_i ? mem_rdata_i : NOP_INSTR;
            if (w_timeout) r_err <= 1'b1;
            r_cnt       <= 8'd0;
            r_state     <= ST_DONE;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          mem_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
